// File: rtl/playback_pkg.sv
// Shared definitions for the playback core: FSM state encoding, register map offsets
// and the sample RAM base offset.
package playback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [2:0] REG_STATE    = 3'd0;
    localparam logic [2:0] REG_START    = 3'd1;
    localparam logic [2:0] REG_STOP     = 3'd2;
    localparam logic [2:0] REG_LENGTH   = 3'd3;
    localparam logic [2:0] REG_LOOP     = 3'd4;
    localparam logic [2:0] REG_READ_PTR = 3'd5;

    localparam int RAM_OFFSET = 8;

    // Number of 16-bit bus words needed to carry one sample.
    function automatic int words_for(input int width);
        return (width + 15) / 16;
    endfunction

endpackage

// File: rtl/playback_if.sv
// Daisy-chain register bus segment: one request per clock, forwarded downstream
// by every core on the chain.
interface playback_if;
    // valid qualifies addr/data/rw for exactly one cycle; there is no ready, so
    // every request is accepted on the cycle it is presented.
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        valid;

    modport master (output addr, data, rw, valid);
    modport slave  (input  addr, data, rw, valid);
endinterface

// File: rtl/playback_sample_ram.sv
// Dual-port sample store built from one 16-bit bank per bus word. Port A is the bus
// side (word-granular write, 1-cycle read); port B replays whole samples.
module playback_sample_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    localparam int WORDS = (WIDTH + 15) / 16,
    localparam int IW    = $clog2(DEPTH),
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    a_idx,
    input  logic [WW-1:0]    a_word,
    input  logic             a_we,
    input  logic [15:0]      a_wdata,
    output logic [15:0]      a_rdata,
    input  logic             b_en,
    input  logic [IW-1:0]    b_idx,
    output logic [WIDTH-1:0] b_rdata
);

    localparam int TOP_BITS = WIDTH - 16 * (WORDS - 1);

    logic [WORDS*16-1:0] a_cat;
    logic [WORDS*16-1:0] b_cat;
    logic [WW-1:0]       a_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) a_word_q <= '0;
        else     a_word_q <= a_word;
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_bank
        // Only the meaningful bits of the top word are stored, so reads return zeros above WIDTH.
        localparam logic [15:0] MASK = (w == WORDS - 1) ? 16'((32'd1 << TOP_BITS) - 32'd1) : 16'hFFFF;

        logic [15:0] mem [DEPTH];
        logic [15:0] a_q;
        logic [15:0] b_q;

        always_ff @(posedge clk) begin
            if (a_we && a_word == WW'(w)) mem[a_idx] <= a_wdata & MASK;
            a_q <= mem[a_idx];
        end

        // Replay register holds the last sample when idle and clears on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)       b_q <= '0;
            else if (b_en) b_q <= mem[b_idx];
        end

        assign a_cat[w*16 +: 16] = a_q;
        assign b_cat[w*16 +: 16] = b_q;
    end

    always_comb begin
        a_rdata = a_cat[15:0];
        for (int w = 0; w < WORDS; w++) begin
            if (a_word_q == WW'(w)) a_rdata = a_cat[w*16 +: 16];
        end
    end

    assign b_rdata = b_cat[WIDTH-1:0];

endmodule

// File: rtl/playback_core.sv
// Sample playback core on the register daisy chain: host fills the sample RAM over the bus,
// then the core replays it one sample per clock. Define PLAYBACK_LOOP_EN for continuous looping.
module playback_core
    import playback_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int WIDTH        = 16
) (
    input  logic             clk,
    input  logic             rst,
    playback_if.slave        bus_in,
    playback_if.master       bus_out,
    input  logic             ext_start_i,
    output logic [WIDTH-1:0] playback_o,
    output logic             playback_valid_o,
    output state_t           state_dbg
);

    localparam int WORDS = words_for(WIDTH);
    localparam int SPAN  = RAM_OFFSET + SAMPLE_DEPTH * WORDS;
    localparam int IW    = $clog2(SAMPLE_DEPTH);
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Address decode on the incoming request.
    logic [31:0]   abs_addr, rel, ram_rel;
    logic          owned, hit_reg, hit_ram, reg_wr, ram_we;
    logic [2:0]    reg_off;
    logic [IW-1:0] a_idx;
    logic [WW-1:0] a_word;

    assign abs_addr = {16'd0, bus_in.addr};
    assign rel      = abs_addr - 32'(BASE_ADDR);
    assign owned    = (abs_addr >= 32'(BASE_ADDR)) && (rel < 32'(SPAN));
    assign hit_reg  = owned && (rel < 32'(RAM_OFFSET));
    assign hit_ram  = owned && !hit_reg;
    assign ram_rel  = rel - 32'(RAM_OFFSET);
    assign a_idx    = IW'(ram_rel / 32'(WORDS));
    assign a_word   = WW'(ram_rel % 32'(WORDS));
    assign reg_off  = rel[2:0];
    assign reg_wr   = bus_in.valid && bus_in.rw && hit_reg;
    assign ram_we   = bus_in.valid && bus_in.rw && hit_ram;

    logic        req_start, req_stop, loop_mode;
    logic [15:0] length;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_start <= 1'b0;
            req_stop  <= 1'b0;
            length    <= '0;
        end else if (reg_wr) begin
            case (reg_off)
                REG_START:  req_start <= bus_in.data[0];
                REG_STOP:   req_stop  <= bus_in.data[0];
                REG_LENGTH: length    <= bus_in.data;
                default:    ;
            endcase
        end
    end

`ifdef PLAYBACK_LOOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               loop_mode <= 1'b0;
        else if (reg_wr && reg_off == REG_LOOP) loop_mode <= bus_in.data[0];
    end
`else
    assign loop_mode = 1'b0;
`endif

    // Control events act in the same cycle the bus write is presented.
    logic start_evt, stop_evt;
    assign start_evt = (reg_wr && reg_off == REG_START && bus_in.data[0] && !req_start) || ext_start_i;
    assign stop_evt  = reg_wr && reg_off == REG_STOP && bus_in.data[0] && !req_stop;

    state_t        state, state_nx;
    logic [IW-1:0] rp, rp_nx;
    logic [31:0]   leff;
    logic          last;

    assign leff = (32'(length) > 32'(SAMPLE_DEPTH)) ? 32'(SAMPLE_DEPTH) : 32'(length);
    assign last = (32'(rp) == leff - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rp    <= '0;
        end else begin
            state <= state_nx;
            rp    <= rp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rp_nx    = rp;
        case (state)
            ST_PLAYING: begin
                if (stop_evt) begin
                    state_nx = ST_IDLE;
                end else if (last) begin
                    if (loop_mode) rp_nx = '0;
                    else           state_nx = ST_DONE;
                end else begin
                    rp_nx = rp + 1'b1;
                end
            end
            default: begin
                if (start_evt && !stop_evt && length != 16'd0) begin
                    state_nx = ST_PLAYING;
                    rp_nx    = '0;
                end
            end
        endcase
    end

    assign state_dbg = state;

    logic        play_en;
    logic [15:0] ram_rdata;

    assign play_en = (state == ST_PLAYING);

    playback_sample_ram #(
        .DEPTH (SAMPLE_DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_idx   (a_idx),
        .a_word  (a_word),
        .a_we    (ram_we),
        .a_wdata (bus_in.data),
        .a_rdata (ram_rdata),
        .b_en    (play_en),
        .b_idx   (rp),
        .b_rdata (playback_o)
    );

    // The replay RAM output lags read_pointer by one cycle, so valid is the delayed PLAYING flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) playback_valid_o <= 1'b0;
        else     playback_valid_o <= play_en;
    end

    // Bus pipeline: stage 1 captures the request while the RAM read is in flight.
    logic [15:0] s1_addr, s1_data, reg_rdata;
    logic        s1_rw, s1_valid, s1_rd_reg, s1_rd_ram;
    logic [2:0]  s1_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_rw     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_rd_reg <= 1'b0;
            s1_rd_ram <= 1'b0;
            s1_off    <= '0;
        end else begin
            s1_addr   <= bus_in.addr;
            s1_data   <= bus_in.data;
            s1_rw     <= bus_in.rw;
            s1_valid  <= bus_in.valid;
            s1_rd_reg <= bus_in.valid && !bus_in.rw && hit_reg;
            s1_rd_ram <= bus_in.valid && !bus_in.rw && hit_ram;
            s1_off    <= reg_off;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (s1_off)
            REG_STATE:    reg_rdata = {14'd0, state};
            REG_START:    reg_rdata = {15'd0, req_start};
            REG_STOP:     reg_rdata = {15'd0, req_stop};
            REG_LENGTH:   reg_rdata = length;
            REG_LOOP:     reg_rdata = {15'd0, loop_mode};
            REG_READ_PTR: reg_rdata = 16'(rp);
            default:      reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_out.addr  <= '0;
            bus_out.data  <= '0;
            bus_out.rw    <= 1'b0;
            bus_out.valid <= 1'b0;
        end else begin
            bus_out.addr  <= s1_addr;
            bus_out.data  <= s1_rd_reg ? reg_rdata : (s1_rd_ram ? ram_rdata : s1_data);
            bus_out.rw    <= s1_rw;
            bus_out.valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_playback_core.sv
// Self-checking bench for playback_core (WIDTH=24, small RAM, non-zero base address);
// expectations come from a sample-array model and the register map rules.
module tb_playback_core;
    import playback_pkg::*;

    localparam int BASE  = 64;
    localparam int DEPTH = 16;
    localparam int W     = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    playback_if bus_in ();
    playback_if bus_out ();

    logic         ext_start = 1'b0;
    logic [W-1:0] pb;
    logic         pb_valid;
    state_t       st_dbg;

    playback_core #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_in           (bus_in),
        .bus_out          (bus_out),
        .ext_start_i      (ext_start),
        .playback_o       (pb),
        .playback_valid_o (pb_valid),
        .state_dbg        (st_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle++;

    // Model and scoreboard
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    int           got_t [$];
    bit           collect = 1'b0;

    always @(negedge clk) begin
        if (collect && pb_valid) begin
            got_q.push_back(pb);
            got_t.push_back(cycle);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] reg_a(input int off);
        return 16'(BASE + off);
    endfunction

    function automatic logic [15:0] ram_a(input int idx, input int w);
        return 16'(BASE + 8 + idx * 2 + w);
    endfunction

    // Driver tasks
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus_in.addr = a; bus_in.data = d; bus_in.rw = 1'b1; bus_in.valid = 1'b1;
        @(posedge clk); #1;
        bus_in.valid = 1'b0; bus_in.rw = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        bus_in.addr = a; bus_in.data = 16'hDEAD; bus_in.rw = 1'b0; bus_in.valid = 1'b1;
        @(posedge clk); #1;
        bus_in.valid = 1'b0;
        @(posedge clk); #1;
        d = bus_out.data;
    endtask

    task automatic write_sample(input int i, input logic [W-1:0] v);
        bus_write(ram_a(i, 0), v[15:0]);
        bus_write(ram_a(i, 1), {8'h00, v[23:16]});
        model_mem[i] = v;
    endtask

    task automatic pulse_ext;
        @(posedge clk); #1 ext_start = 1'b1;
        @(posedge clk); #1 ext_start = 1'b0;
    endtask

    task automatic wait_state(input logic [15:0] want, output logic [15:0] st);
        st = 16'hFFFF;
        for (int i = 0; i < 60; i++) begin
            bus_read(reg_a(0), st);
            if (st == want) break;
        end
    endtask

    task automatic do_play(input int len, input bit use_ext, output logic [15:0] st);
        got_q.delete(); got_t.delete();
        collect = 1'b1;
        bus_write(reg_a(3), 16'(len));
        if (use_ext) pulse_ext();
        else         bus_write(reg_a(1), 16'h0001);
        wait_state(16'd2, st);
        repeat (3) @(posedge clk);
        collect = 1'b0;
        if (!use_ext) bus_write(reg_a(1), 16'h0000);
    endtask

    task automatic do_reset;
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Tests
    task automatic test_reset;
        logic [15:0] d;
        #1 rst = 1'b1;
        bus_in.addr = '0; bus_in.data = '0; bus_in.rw = 1'b0; bus_in.valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pb !== '0)            begin errors++; $display("FAIL reset_pb: got %h want 0", pb); end
        checks++; if (pb_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", pb_valid); end
        checks++; if ({bus_out.addr, bus_out.data, bus_out.rw, bus_out.valid} !== 34'd0)
            begin errors++; $display("FAIL reset_bus_out: got %h/%h want 0/0", bus_out.addr, bus_out.data); end
        checks++; if (st_dbg !== ST_IDLE)   begin errors++; $display("FAIL reset_state_dbg: got %0d want 0", st_dbg); end
        #1 rst = 1'b0;
        bus_read(reg_a(0), d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_state_reg: got %h want 0", d); end
        bus_read(reg_a(3), d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_length: got %h want 0", d); end
        bus_read(reg_a(5), d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL reset_read_ptr: got %h want 0", d); end
    endtask

    task automatic test_passthrough;
        logic [33:0] pt_q [$];
        logic [33:0] tx, obs;
        logic [15:0] a, d;
        logic        rw, v;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                a = 16'h0010; d = 16'h1234; rw = 1'b1; v = 1'b1;
            end else begin
                if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, BASE - 1));
                else                           a = 16'($urandom_range(BASE + 8 + 2 * DEPTH, 65535));
                d  = 16'($urandom);
                rw = 1'($urandom_range(0, 1));
                v  = (i < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus_in.addr = a; bus_in.data = d; bus_in.rw = rw; bus_in.valid = v;
            pt_q.push_back({a, d, rw, v});
            @(negedge clk);
            if (i >= 2) begin
                tx  = pt_q.pop_front();
                obs = {bus_out.addr, bus_out.data, bus_out.rw, bus_out.valid};
                checks++;
                if (obs !== tx) begin errors++; $display("FAIL passthrough[%0d]: got %h want %h", i - 2, obs, tx); end
            end
        end
        @(posedge clk); #1 bus_in.valid = 1'b0; bus_in.rw = 1'b0;
    endtask

    task automatic test_registers;
        logic [15:0] d;
        bus_write(reg_a(3), 16'h1234);
        bus_read(reg_a(3), d);
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL reg_length: got %h want 1234", d); end
        bus_write(reg_a(6), 16'hFFFF);
        bus_read(reg_a(6), d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_reserved6: got %h want 0", d); end
        bus_read(reg_a(7), d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_reserved7: got %h want 0", d); end
        bus_write(reg_a(0), 16'h0003);
        bus_read(reg_a(0), d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_state_ro: got %h want 0", d); end
        bus_write(reg_a(5), 16'h0005);
        bus_read(reg_a(5), d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_read_ptr_ro: got %h want 0", d); end
        bus_write(reg_a(4), 16'h0001);
        bus_read(reg_a(4), d);
`ifdef PLAYBACK_LOOP_EN
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL reg_loop: got %h want 1", d); end
`else
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_loop: got %h want 0", d); end
`endif
        bus_write(reg_a(4), 16'h0000);
        bus_write(reg_a(3), 16'h0000);
    endtask

    task automatic test_ram_rw;
        logic [15:0] d, want;
        int          idx, w;
        for (int i = 0; i < DEPTH; i++) write_sample(i, W'($urandom));
        for (int k = 0; k < 10; k++) begin
            idx  = $urandom_range(0, DEPTH - 1);
            w    = $urandom_range(0, 1);
            want = (w == 0) ? model_mem[idx][15:0] : {8'h00, model_mem[idx][23:16]};
            bus_read(ram_a(idx, w), d);
            checks++; if (d !== want) begin errors++; $display("FAIL ram_rw[%0d.%0d]: got %h want %h", idx, w, d, want); end
        end
    endtask

    task automatic test_basic_playback;
        logic [15:0] st, d;
        for (int i = 0; i < 4; i++) write_sample(i, W'(i + 1));
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[i]);
        do_play(4, 1'b0, st);
        checks++; if (st !== 16'd2) begin errors++; $display("FAIL basic_state: got %h want 2", st); end
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_sample[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 4) begin
            checks++; if (got_t[3] - got_t[0] != 3) begin errors++; $display("FAIL basic_gap: got span %0d want 3", got_t[3] - got_t[0]); end
        end
        bus_read(reg_a(5), d);
        checks++; if (d !== 16'd3) begin errors++; $display("FAIL basic_read_ptr: got %h want 3", d); end
        @(negedge clk);
        checks++; if (pb !== exp_q[3] || pb_valid !== 1'b0)
            begin errors++; $display("FAIL basic_hold: got %h/%b want %h/0", pb, pb_valid, exp_q[3]); end
    endtask

    task automatic test_random_lengths;
        logic [15:0] st;
        int          len;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < DEPTH; i++) write_sample(i, W'($urandom));
            len = $urandom_range(1, DEPTH);
            exp_q.delete();
            for (int i = 0; i < len; i++) exp_q.push_back(model_mem[i]);
            do_play(len, it[0], st);
            checks++; if (st !== 16'd2) begin errors++; $display("FAIL rand_state[%0d]: got %h want 2", it, st); end
            checks++; if (got_q.size() !== len) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, got_q.size(), len); end
            for (int i = 0; i < got_q.size() && i < len; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_sample[%0d.%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_over_length;
        logic [15:0] st;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
        do_play(DEPTH + 5, 1'b1, st);
        checks++; if (st !== 16'd2) begin errors++; $display("FAIL over_state: got %h want 2", st); end
        checks++; if (got_q.size() !== DEPTH) begin errors++; $display("FAIL over_count: got %0d want %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL over_sample[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == DEPTH) begin
            checks++; if (got_t[DEPTH-1] - got_t[0] != DEPTH - 1) begin errors++; $display("FAIL over_gap: got span %0d", got_t[DEPTH-1] - got_t[0]); end
        end
    endtask

    task automatic test_zero_length;
        logic [15:0] st, d;
        do_reset();
        bus_read(ram_a(0, 0), d);
        checks++; if (d !== model_mem[0][15:0]) begin errors++; $display("FAIL zero_ram_kept: got %h want %h", d, model_mem[0][15:0]); end
        got_q.delete(); collect = 1'b1;
        bus_write(reg_a(1), 16'h0001);
        pulse_ext();
        repeat (10) @(posedge clk);
        bus_read(reg_a(0), st);
        collect = 1'b0;
        checks++; if (st !== 16'd0) begin errors++; $display("FAIL zero_state: got %h want 0", st); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL zero_count: got %0d want 0", got_q.size()); end
        bus_write(reg_a(1), 16'h0000);
    endtask

    task automatic test_loop;
        logic [15:0] st, d;
        logic [W-1:0] pat [3];
        int n;
        for (int i = 0; i < 3; i++) begin
            pat[i] = W'($urandom);
            write_sample(i, pat[i]);
        end
        bus_write(reg_a(4), 16'h0001);
        got_q.delete(); got_t.delete(); collect = 1'b1;
        bus_write(reg_a(3), 16'd3);
        bus_write(reg_a(1), 16'h0001);
`ifdef PLAYBACK_LOOP_EN
        repeat (20) @(posedge clk);
        bus_write(reg_a(2), 16'h0001);
        repeat (4) @(posedge clk);
        bus_read(reg_a(0), st);
        checks++; if (st !== 16'd0) begin errors++; $display("FAIL loop_stop_state: got %h want 0", st); end
        n = got_q.size();
        checks++; if (n < 6) begin errors++; $display("FAIL loop_count: got %0d want >=6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_q[i] !== pat[i % 3]) begin errors++; $display("FAIL loop_sample[%0d]: got %h want %h", i, got_q[i], pat[i % 3]); end
        end
        if (n > 0) begin
            checks++; if (got_t[n-1] - got_t[0] != n - 1) begin errors++; $display("FAIL loop_gap: got span %0d want %0d", got_t[n-1] - got_t[0], n - 1); end
        end
        repeat (10) @(posedge clk);
        checks++; if (got_q.size() !== n) begin errors++; $display("FAIL loop_after_stop: got %0d want %0d", got_q.size(), n); end
        bus_write(reg_a(2), 16'h0000);
`else
        wait_state(16'd2, st);
        repeat (3) @(posedge clk);
        checks++; if (st !== 16'd2) begin errors++; $display("FAIL oneshot_state: got %h want 2", st); end
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL oneshot_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if (got_q[i] !== pat[i]) begin errors++; $display("FAIL oneshot_sample[%0d]: got %h want %h", i, got_q[i], pat[i]); end
        end
        bus_read(reg_a(4), d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL oneshot_loop_reg: got %h want 0", d); end
`endif
        collect = 1'b0;
        bus_write(reg_a(1), 16'h0000);
        bus_write(reg_a(4), 16'h0000);
    endtask

    task automatic test_reset_mid;
        logic [15:0] st;
        got_q.delete(); collect = 1'b1;
        bus_write(reg_a(3), 16'(DEPTH));
        pulse_ext();
        repeat (4) @(posedge clk);
        checks++; if (got_q.size() == 0) begin errors++; $display("FAIL mid_started: got 0 samples want >0"); end
        #2 rst = 1'b1;
        got_q.delete();
        @(posedge clk); #1;
        checks++; if (pb !== '0 || pb_valid !== 1'b0) begin errors++; $display("FAIL mid_outputs: got %h/%b want 0/0", pb, pb_valid); end
        checks++; if (st_dbg !== ST_IDLE) begin errors++; $display("FAIL mid_state_dbg: got %0d want 0", st_dbg); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        bus_read(reg_a(0), st);
        collect = 1'b0;
        checks++; if (st !== 16'd0) begin errors++; $display("FAIL mid_state: got %h want 0", st); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_no_samples: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_stop_start_same;
        logic [15:0] st;
        bus_write(reg_a(3), 16'd8);
        got_q.delete(); collect = 1'b1;
        @(posedge clk); #1;
        bus_in.addr = reg_a(2); bus_in.data = 16'h0001; bus_in.rw = 1'b1; bus_in.valid = 1'b1; ext_start = 1'b1;
        @(posedge clk); #1;
        bus_in.valid = 1'b0; bus_in.rw = 1'b0; ext_start = 1'b0;
        repeat (10) @(posedge clk);
        bus_read(reg_a(0), st);
        checks++; if (st !== 16'd0) begin errors++; $display("FAIL same_idle_state: got %h want 0", st); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL same_idle_count: got %0d want 0", got_q.size()); end
        bus_write(reg_a(2), 16'h0000);
        pulse_ext();
        @(posedge clk); #1;
        bus_in.addr = reg_a(2); bus_in.data = 16'h0001; bus_in.rw = 1'b1; bus_in.valid = 1'b1; ext_start = 1'b1;
        @(posedge clk); #1;
        bus_in.valid = 1'b0; bus_in.rw = 1'b0; ext_start = 1'b0;
        repeat (3) @(posedge clk);
        bus_read(reg_a(0), st);
        collect = 1'b0;
        checks++; if (st !== 16'd0) begin errors++; $display("FAIL same_play_state: got %h want 0", st); end
        checks++; if (got_q.size() == 0 || got_q.size() >= 8) begin errors++; $display("FAIL same_play_count: got %0d want 1..7", got_q.size()); end
        @(negedge clk);
        checks++; if (pb_valid !== 1'b0) begin errors++; $display("FAIL same_play_valid: got %b want 0", pb_valid); end
        bus_write(reg_a(2), 16'h0000);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_registers();
        test_ram_rw();
        test_basic_playback();
        test_random_lengths();
        test_over_length();
        test_zero_length();
        test_loop();
        test_reset_mid();
        test_stop_start_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
